// File: rtl/led_pwm_pio_pkg.sv
// Shared register map and STATUS layout for the LED PWM PIO block.
package led_pwm_pio_pkg;

  localparam logic [2:0] ADDR_DATA         = 3'd0;
  localparam logic [2:0] ADDR_OUTSET       = 3'd1;
  localparam logic [2:0] ADDR_OUTCLEAR     = 3'd2;
  localparam logic [2:0] ADDR_BLINK        = 3'd3;
  localparam logic [2:0] ADDR_PRESCALE     = 3'd4;
  localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd5;
  localparam logic [2:0] ADDR_DUTY         = 3'd6;
  localparam logic [2:0] ADDR_STATUS       = 3'd7;

  localparam int STATUS_PHASE_BIT = 0;
  localparam int STATUS_PWM_LSB   = 8;

  localparam int TIMER_W = 16;

endpackage

// File: rtl/led_pwm_timebase.sv
// Prescaler, PWM frame counter and blink phase generator shared by all LED channels.
module led_pwm_timebase
  import led_pwm_pio_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [TIMER_W-1:0]  prescale,
  input  logic [TIMER_W-1:0]  blink_period,
  input  logic [PWM_BITS-1:0] duty,
  input  logic                restart,
  input  logic                blink_restart,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                pwm_on,
  output logic                blink_phase
);

  logic [TIMER_W-1:0] presc_cnt;
  logic [TIMER_W-1:0] blink_cnt;
  logic               tick;
  logic               frame_end;

  assign tick      = (presc_cnt == prescale);
  assign frame_end = tick && (pwm_cnt == '1);
  assign pwm_on    = (pwm_cnt < duty) || (duty == '1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
    end else if (restart) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
      pwm_cnt   <= pwm_cnt + 1'b1;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

  // A register write that restarts the blink timer wins over a coinciding toggle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (restart || blink_restart) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (frame_end) begin
      if (blink_cnt == blink_period) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_pwm_pio.sv
// Avalon-MM LED port with per-bit set/clear, global PWM dimming and masked blinking.
module led_pwm_pio
  import led_pwm_pio_pkg::*;
#(
  parameter int               WIDTH       = 10,
  parameter int               PWM_BITS    = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0]    data;
  logic [WIDTH-1:0]    blink;
  logic [TIMER_W-1:0]  prescale;
  logic [TIMER_W-1:0]  blink_period;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_on;
  logic                blink_phase;
  logic                wr_en;
  logic                wdata_unused;

  assign wr_en        = chipselect && !write_n;
  assign wdata_unused = ^writedata[31:16];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data         <= RESET_VALUE;
      blink        <= '0;
      prescale     <= '0;
      blink_period <= '0;
      duty         <= '1;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:         data         <= writedata[WIDTH-1:0];
        ADDR_OUTSET:       data         <= data | writedata[WIDTH-1:0];
        ADDR_OUTCLEAR:     data         <= data & ~writedata[WIDTH-1:0];
        ADDR_BLINK:        blink        <= writedata[WIDTH-1:0];
        ADDR_PRESCALE:     prescale     <= writedata[TIMER_W-1:0];
        ADDR_BLINK_PERIOD: blink_period <= writedata[TIMER_W-1:0];
        ADDR_DUTY:         duty         <= writedata[PWM_BITS-1:0];
        default:           ;
      endcase
    end
  end

  led_pwm_timebase #(
    .PWM_BITS (PWM_BITS)
  ) u_timebase (
    .clk           (clk),
    .reset         (reset),
    .prescale      (prescale),
    .blink_period  (blink_period),
    .duty          (duty),
    .restart       (wr_en && (address == ADDR_PRESCALE)),
    .blink_restart (wr_en && (address == ADDR_BLINK_PERIOD)),
    .pwm_cnt       (pwm_cnt),
    .pwm_on        (pwm_on),
    .blink_phase   (blink_phase)
  );

  // Output stage: one register between the control registers and the pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_port <= RESET_VALUE;
    end else begin
      out_port <= data & {WIDTH{pwm_on}} & (~blink | {WIDTH{blink_phase}});
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA, ADDR_OUTSET, ADDR_OUTCLEAR: readdata[WIDTH-1:0] = data;
      ADDR_BLINK:        readdata[WIDTH-1:0]   = blink;
      ADDR_PRESCALE:     readdata[TIMER_W-1:0] = prescale;
      ADDR_BLINK_PERIOD: readdata[TIMER_W-1:0] = blink_period;
      ADDR_DUTY:         readdata[PWM_BITS-1:0] = duty;
      ADDR_STATUS: begin
        readdata[STATUS_PHASE_BIT]               = blink_phase;
        readdata[STATUS_PWM_LSB +: PWM_BITS]     = pwm_cnt;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_led_pwm_pio.sv
// Directed bench for led_pwm_pio: register map, set/clear, PWM duty, blink and timebase restart.
module tb_led_pwm_pio;

  localparam int WIDTH    = 10;
  localparam int PWM_BITS = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [2:0]       address = '0;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = '0;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;

  int total = 0;
  int bad   = 0;

  led_pwm_pio #(
    .WIDTH       (WIDTH),
    .PWM_BITS    (PWM_BITS),
    .RESET_VALUE (10'h2A5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] duties [3];
    int          exp_hi [3];
    int          hi, lo, errs;
    logic        exp0;
    logic [9:0]  exp_out;

    duties = '{32'd64, 32'd255, 32'd0};
    exp_hi = '{64, 256, 0};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_init", {22'd0, out_port}, 32'h2A5);
    rd_chk("rst_data_init", 3'd0, 32'h2A5);

    @(negedge clk);
    reset = 1'b0;
    wr(3'd4, 32'd7);
    wr(3'd0, 32'h155);
    repeat (3) @(posedge clk);
    #1;
    chk("out_before_reset", {22'd0, out_port}, 32'h155);
    rd_chk("presc_before_reset", 3'd4, 32'd7);

    // Asynchronous reset mid-count: no clock edge between assert and checks
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_out_async", {22'd0, out_port}, 32'h2A5);
    rd_chk("rst_presc", 3'd4, 32'd0);
    rd_chk("rst_data", 3'd0, 32'h2A5);
    rd_chk("rst_duty", 3'd6, 32'hFF);
    rd_chk("rst_status", 3'd7, 32'h1);
    rd_chk("rst_blink", 3'd3, 32'h0);
    rd_chk("rst_bperiod", 3'd5, 32'h0);
    wr(3'd0, 32'h3FF);
    rd_chk("wr_during_reset", 3'd0, 32'h2A5);

    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rd_chk("count_after_reset", 3'd7, 32'h1401);

    // Set / clear
    wr(3'd0, 32'h0F0);
    wr(3'd1, 32'h003);
    wr(3'd2, 32'h030);
    chk("out_lag", {22'd0, out_port}, 32'h0F3);
    rd_chk("setclr_data", 3'd0, 32'h0C3);
    @(posedge clk);
    #1;
    chk("setclr_out", {22'd0, out_port}, 32'h0C3);
    rd_chk("rd_outset", 3'd1, 32'h0C3);
    rd_chk("rd_outclear", 3'd2, 32'h0C3);

    // Upper writedata bits and STATUS writes ignored
    wr(3'd0, 32'hFFFF_F0C3);
    rd_chk("data_trunc", 3'd0, 32'h0C3);
    wr(3'd6, 32'hFFFF_FF40);
    rd_chk("duty_trunc", 3'd6, 32'h40);
    wr(3'd7, 32'hFFFF_FFFF);
    rd_chk("status_wr_data", 3'd0, 32'h0C3);
    rd_chk("status_wr_duty", 3'd6, 32'h40);

    // PWM duty
    wr(3'd0, 32'h3FF);
    wr(3'd4, 32'd0);
    for (int k = 0; k < 3; k++) begin
      wr(3'd6, duties[k]);
      hi = 0;
      lo = 0;
      for (int i = 0; i < 256; i++) begin
        @(posedge clk);
        #1;
        if (out_port == 10'h3FF) hi++;
        else if (out_port == 10'h000) lo++;
      end
      chk($sformatf("pwm_hi_d%0d", duties[k]), hi, exp_hi[k]);
      chk($sformatf("pwm_lo_d%0d", duties[k]), lo, 256 - exp_hi[k]);
    end

    // Blink on bit 0, toggling every two frames
    wr(3'd6, 32'd255);
    wr(3'd3, 32'h001);
    wr(3'd5, 32'd1);
    wr(3'd4, 32'd0);
    address = 3'd7;
    errs = 0;
    for (int n = 1; n <= 1025; n++) begin
      @(posedge clk);
      #1;
      exp0    = (((n - 1) / 512) % 2) == 0;
      exp_out = {9'h1FF, exp0};
      if (out_port !== exp_out) errs++;
      if (n == 511) chk("blink_status_511", readdata, 32'hFF01);
      if (n == 512) begin
        chk("blink_status_512", readdata, 32'h0000);
        chk("blink_out_512", {22'd0, out_port}, 32'h3FF);
      end
      if (n == 513) chk("blink_out_513", {22'd0, out_port}, 32'h3FE);
      if (n == 1024) chk("blink_out_1024", {22'd0, out_port}, 32'h3FE);
      if (n == 1025) chk("blink_out_1025", {22'd0, out_port}, 32'h3FF);
    end
    chk("blink_errs", errs, 0);

    // Timebase restart with PRESCALE=3
    repeat (37) @(posedge clk);
    wr(3'd4, 32'd3);
    rd_chk("restart_pwm0", 3'd7, 32'h0001);
    repeat (3) @(posedge clk);
    #1;
    chk("restart_e3", readdata, 32'h0001);
    @(posedge clk);
    #1;
    chk("restart_e4", readdata, 32'h0101);
    repeat (3) @(posedge clk);
    #1;
    chk("restart_e7", readdata, 32'h0101);
    @(posedge clk);
    #1;
    chk("restart_e8", readdata, 32'h0201);

    // BLINK_PERIOD write landing on frame_end
    wr(3'd5, 32'd0);
    wr(3'd4, 32'd0);
    repeat (255) @(posedge clk);
    wr(3'd5, 32'd1);
    rd_chk("collide_phase", 3'd7, 32'h0001);
    repeat (256) @(posedge clk);
    rd_chk("collide_next_frame", 3'd7, 32'h0001);
    repeat (256) @(posedge clk);
    rd_chk("collide_toggle", 3'd7, 32'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
